// File: rtl/comp_rr_arbiter.sv
// rtl/comp_rr_arbiter.sv - round-robin arbiter sharing one unsigned greater-than comparator
module comp_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_c,
  output logic [ID_W-1:0]    rsp_id
);

  logic [ID_W-1:0]  last_gnt;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             accept;
  logic [W-1:0]     a_arr [N_REQ];
  logic [W-1:0]     b_arr [N_REQ];
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic             cmp;

  // Unpack the flat operand buses so the winner can be selected by index.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*W +: W];
    assign b_arr[g] = req_b[g*W +: W];
  end

  // Output slot is free when empty or when the current response drains this cycle.
  assign accept = !rsp_valid || rsp_ready;

  // Round-robin search starting just above the last winner, wrapping to 0.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = ID_W'((int'(last_gnt) + off) % N_REQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any      = 1'b1;
        gnt_idx      = idx;
        grant[idx]   = 1'b1;
      end
    end
  end

  // Grant is only offered when the slot can take it and never during reset.
  assign req_ready = grant & {N_REQ{accept && aresetn}};

  // Single shared comparator fed by the winning requester's operands.
  always_comb begin
    sel_a = a_arr[gnt_idx];
    sel_b = b_arr[gnt_idx];
    cmp   = sel_a > sel_b;
  end

  // Response register and round-robin pointer; stalls hold everything.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_valid <= 1'b0;
      rsp_c     <= 1'b0;
      rsp_id    <= '0;
      last_gnt  <= ID_W'(N_REQ - 1);
    end else if (accept) begin
      rsp_valid <= gnt_any;
      if (gnt_any) begin
        rsp_c    <= cmp;
        rsp_id   <= gnt_idx;
        last_gnt <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_comp_rr_arbiter.sv
// tb/tb_comp_rr_arbiter.sv - scoreboard bench for comp_rr_arbiter
module tb_comp_rr_arbiter;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct packed {
    logic [1:0] id;
    logic       c;
  } exp_t;

  logic        clk;
  logic        aresetn;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_c;
  logic [1:0]  rsp_id;

  op_t  rq [4][$];
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  comp_rr_arbiter #(.N_REQ(4), .W(8), .ID_W(2)) dut (
    .clk(clk), .aresetn(aresetn), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_id(rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_op(input int r, input logic [7:0] a, input logic [7:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    rq[r].push_back(o);
  endtask

  task automatic push_exp(input logic [1:0] id, input logic c);
    exp_t e;
    e.id = id;
    e.c  = c;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 80 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_rsp(input string name, input logic [1:0] id);
    int k;
    k = 0;
    while (!(rsp_valid && rsp_id == id) && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (k >= 80) check(name, 32'hdead, {30'd0, id});
  endtask

  // Requester model: hold each queued op until the DUT accepts it.
  initial begin
    logic [3:0] acc;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]     = 1'b1;
          req_a[i*8 +: 8]  = rq[i][0].a;
          req_b[i*8 +: 8]  = rq[i][0].b;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every completed response handshake is compared with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (aresetn && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {30'd0, rsp_id}, 32'hffff);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
          check("rsp_c", {31'd0, rsp_c}, {31'd0, e.c});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn   = 1'b0;
    rsp_ready = 1'b1;

    // Test 1: reset with all requesters pending, then first grant to req 0.
    push_op(0, 8'd1, 8'd0);   push_exp(2'd0, 1'b1);
    push_op(1, 8'd5, 8'd9);   push_exp(2'd1, 1'b0);
    push_op(2, 8'd100, 8'd99); push_exp(2'd2, 1'b1);
    push_op(3, 8'd7, 8'd7);   push_exp(2'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", {28'd0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'h0);
    check("rst_rsp_id", {30'd0, rsp_id}, 32'h0);
    check("rst_rsp_c", {31'd0, rsp_c}, 32'h0);
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    check("first_grant", {28'd0, req_ready}, 32'h1);
    drain("t1_drain");

    // Test 2: req 0 alone, grant visible in the same cycle.
    @(negedge clk);
    push_op(0, 8'd10, 8'd15); push_exp(2'd0, 1'b0);
    push_op(0, 8'd20, 8'd15); push_exp(2'd0, 1'b1);
    @(negedge clk);
    check("t2_req_ready", {28'd0, req_ready}, 32'h1);
    drain("t2_drain");

    // Test 3: req 2 boundary operands.
    @(negedge clk);
    push_op(2, 8'd35, 8'd35);  push_exp(2'd2, 1'b0);
    push_op(2, 8'd255, 8'd0);  push_exp(2'd2, 1'b1);
    push_op(2, 8'd0, 8'd255);  push_exp(2'd2, 1'b0);
    drain("t3_drain");

    // Test 4: reset priority, then all four continuously valid, no bubbles.
    @(posedge clk); #1 aresetn = 1'b0;
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    push_op(0, 8'd3, 8'd2);     push_op(0, 8'd0, 8'd0);
    push_op(1, 8'd128, 8'd127); push_op(1, 8'd127, 8'd128);
    push_op(2, 8'd9, 8'd200);   push_op(2, 8'd200, 8'd9);
    push_op(3, 8'd255, 8'd254); push_op(3, 8'd1, 8'd1);
    push_exp(2'd0, 1'b1); push_exp(2'd1, 1'b1); push_exp(2'd2, 1'b0); push_exp(2'd3, 1'b1);
    push_exp(2'd0, 1'b0); push_exp(2'd1, 1'b0); push_exp(2'd2, 1'b1); push_exp(2'd3, 1'b0);
    wait_rsp("t4_start", 2'd0);
    for (int k = 0; k < 8; k++) begin
      check("t4_no_bubble", {31'd0, rsp_valid}, 32'h1);
      @(negedge clk);
    end
    check("t4_idle_after", {31'd0, rsp_valid}, 32'h0);
    drain("t4_drain");

    // Test 5: back-pressure holds the id=1 response.
    @(negedge clk);
    push_op(0, 8'd50, 8'd40);   push_op(0, 8'd40, 8'd50);
    push_op(1, 8'd0, 8'd1);     push_op(1, 8'd1, 8'd0);
    push_op(2, 8'd77, 8'd77);   push_op(2, 8'd78, 8'd77);
    push_op(3, 8'd254, 8'd255); push_op(3, 8'd255, 8'd255);
    push_exp(2'd0, 1'b1); push_exp(2'd1, 1'b0); push_exp(2'd2, 1'b0); push_exp(2'd3, 1'b0);
    push_exp(2'd0, 1'b0); push_exp(2'd1, 1'b1); push_exp(2'd2, 1'b1); push_exp(2'd3, 1'b0);
    wait_rsp("t5_start", 2'd0);
    @(posedge clk); #1 rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'h1);
      check("stall_id", {30'd0, rsp_id}, 32'h1);
      check("stall_c", {31'd0, rsp_c}, 32'h0);
      check("stall_req_ready", {28'd0, req_ready}, 32'h0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain("t5_drain");

    // Test 6: async reset while id=2 is presented.
    @(negedge clk);
    push_op(0, 8'd12, 8'd11);  push_exp(2'd0, 1'b1);
    push_op(1, 8'd11, 8'd12);  push_exp(2'd1, 1'b0);
    push_op(2, 8'd200, 8'd100); push_exp(2'd2, 1'b1);
    push_op(3, 8'd0, 8'd0);
    wait_rsp("t6_start", 2'd2);
    #2 aresetn = 1'b0;
    #1;
    check("async_rsp_valid", {31'd0, rsp_valid}, 32'h0);
    check("async_req_ready", {28'd0, req_ready}, 32'h0);
    for (int i = 0; i < 4; i++) rq[i].delete();
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    check("t6_exp_empty", exp_q.size(), 0);
    push_op(0, 8'd9, 8'd8);    push_exp(2'd0, 1'b1);
    push_op(1, 8'd8, 8'd9);    push_exp(2'd1, 1'b0);
    push_op(2, 8'd128, 8'd0);  push_exp(2'd2, 1'b1);
    push_op(3, 8'd0, 8'd128);  push_exp(2'd3, 1'b0);
    drain("t6_drain");

    repeat (3) @(negedge clk);
    check("final_idle", {31'd0, rsp_valid}, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
